// File: rtl/register_file.sv
// 32 x 32 general-purpose register file: two combinational read ports, one
// synchronous write port, register 0 hard-wired to zero.
module register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  reg_write,
    input  logic [ADDR_WIDTH-1:0] read_addr1,
    input  logic [ADDR_WIDTH-1:0] read_addr2,
    input  logic [ADDR_WIDTH-1:0] write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic [DATA_WIDTH-1:0] read_data1,
    output logic [DATA_WIDTH-1:0] read_data2
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (reg_write && (write_addr != '0)) begin
            regs[write_addr] <= write_data;
        end
    end

    // No write bypass: a same-cycle write shows up only after the edge.
    assign read_data1 = (read_addr1 == '0) ? '0 : regs[read_addr1];
    assign read_data2 = (read_addr2 == '0) ? '0 : regs[read_addr2];

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file: reset, write/readback,
// $zero protection, dual read, read-before-write and asynchronous reset.
module tb_register_file;

    logic        clk;
    logic        rst;
    logic        reg_write;
    logic [4:0]  read_addr1;
    logic [4:0]  read_addr2;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [31:0] read_data1;
    logic [31:0] read_data2;

    int check_cnt = 0;
    int pass_cnt  = 0;

    register_file #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .reg_write  (reg_write),
        .read_addr1 (read_addr1),
        .read_addr2 (read_addr2),
        .write_addr (write_addr),
        .write_data (write_data),
        .read_data1 (read_data1),
        .read_data2 (read_data2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // One write: drive at the falling edge, commit on the next rising edge.
    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        write_addr = a;
        write_data = d;
        reg_write  = 1'b1;
        @(posedge clk);
        #1;
        reg_write  = 1'b0;
    endtask

    task automatic rd1(input logic [4:0] a, input string tag, input logic [31:0] exp);
        read_addr1 = a;
        #1;
        check(tag, read_data1, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit, got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b0;
        reg_write  = 1'b0;
        read_addr1 = 5'd0;
        read_addr2 = 5'd5;
        write_addr = 5'd0;
        write_data = 32'h0;

        // Reset held for two cycles; a write attempted meanwhile is ignored.
        @(negedge clk);
        write_addr = 5'd5;
        write_data = 32'hFFFF_FFFF;
        reg_write  = 1'b1;
        @(negedge clk);
        reg_write  = 1'b0;
        check("rst_low_r0", read_data1, 32'h0);
        check("rst_low_r5", read_data2, 32'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_rel_r0", read_data1, 32'h0);
        check("rst_rel_r5", read_data2, 32'h0);

        // Write / readback and persistence.
        wr(5'd5, 32'hDEAD_BEEF);
        rd1(5'd5, "wr_r5", 32'hDEAD_BEEF);
        wr(5'd10, 32'hCAFE_CAFE);
        rd1(5'd10, "wr_r10", 32'hCAFE_CAFE);
        rd1(5'd5, "persist_r5", 32'hDEAD_BEEF);

        // reg_write low: no change even with data/address presented.
        @(negedge clk);
        write_addr = 5'd5;
        write_data = 32'h0BAD_0BAD;
        @(posedge clk);
        #1;
        rd1(5'd5, "no_we_r5", 32'hDEAD_BEEF);

        // $zero protection on both ports.
        wr(5'd0, 32'h1234_5678);
        read_addr1 = 5'd0;
        read_addr2 = 5'd0;
        #1;
        check("zero_p1", read_data1, 32'h0);
        check("zero_p2", read_data2, 32'h0);

        // Dual read, then both ports on the same register.
        read_addr1 = 5'd5;
        read_addr2 = 5'd10;
        #1;
        check("dual_p1", read_data1, 32'hDEAD_BEEF);
        check("dual_p2", read_data2, 32'hCAFE_CAFE);
        read_addr2 = 5'd5;
        #1;
        check("same_p2", read_data2, 32'hDEAD_BEEF);

        // Read-before-write on reg 12.
        wr(5'd12, 32'd100);
        @(negedge clk);
        read_addr1 = 5'd12;
        write_addr = 5'd12;
        write_data = 32'd999;
        reg_write  = 1'b1;
        #1;
        check("rbw_old", read_data1, 32'd100);
        @(posedge clk);
        #1;
        reg_write = 1'b0;
        #1;
        check("rbw_new", read_data1, 32'd999);

        // Asynchronous reset between edges clears everything at once.
        @(negedge clk);
        #2;
        read_addr1 = 5'd5;
        read_addr2 = 5'd10;
        rst = 1'b0;
        #1;
        check("arst_r5", read_data1, 32'h0);
        check("arst_r10", read_data2, 32'h0);
        read_addr1 = 5'd12;
        #1;
        check("arst_r12", read_data1, 32'h0);

        // Write attempt while reset is still low has no effect.
        write_addr = 5'd7;
        write_data = 32'h0000_0055;
        reg_write  = 1'b1;
        read_addr1 = 5'd7;
        @(posedge clk);
        #1;
        check("arst_wr_r7", read_data1, 32'h0);

        // Reset released with a write pending: the write at that edge proceeds.
        @(negedge clk);
        rst        = 1'b1;
        write_addr = 5'd3;
        write_data = 32'hA5A5_5A5A;
        read_addr2 = 5'd3;
        @(posedge clk);
        #1;
        reg_write = 1'b0;
        check("rel_wr_r3", read_data2, 32'hA5A5_5A5A);
        check("rel_r7", read_data1, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
